// File: rtl/systolic_conv_ctrl_pkg.sv
// Shared tile geometry and controller state encoding for the 4x4 / 3x3 systolic
// convolution controller.
package systolic_conv_ctrl_pkg;

  localparam int IMG_N   = 4;
  localparam int K       = 3;
  localparam int OUT_N   = 2;
  localparam int TAPS    = K * K;
  localparam int WINDOWS = OUT_N * OUT_N;
  localparam int IMG_SZ  = IMG_N * IMG_N;
  localparam int FLT_SZ  = K * K;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IMG,
    LOAD_FLT,
    RUN,
    DRAIN,
    OUT
  } state_e;

endpackage

// File: rtl/systolic_conv_addr_gen.sv
// Maps the (window, tap) issue counters onto image and filter buffer indices
// and flags the first and last tap of each window.
module systolic_conv_addr_gen
  import systolic_conv_ctrl_pkg::*;
(
  input  logic [1:0] win,
  input  logic [3:0] tap,
  output logic [3:0] img_idx,
  output logic [3:0] flt_idx,
  output logic       tap_first,
  output logic       tap_last
);

  logic [1:0] ti;
  logic [1:0] tj;
  logic [1:0] row;
  logic [1:0] col;

  always_comb begin
    ti = 2'd0;
    tj = 2'd0;
    case (tap)
      4'd1: tj = 2'd1;
      4'd2: tj = 2'd2;
      4'd3: ti = 2'd1;
      4'd4: begin ti = 2'd1; tj = 2'd1; end
      4'd5: begin ti = 2'd1; tj = 2'd2; end
      4'd6: ti = 2'd2;
      4'd7: begin ti = 2'd2; tj = 2'd1; end
      4'd8: begin ti = 2'd2; tj = 2'd2; end
      default: begin ti = 2'd0; tj = 2'd0; end
    endcase
  end

  // Window index bit 1 is the output row, bit 0 the output column.
  assign row       = {1'b0, win[1]} + ti;
  assign col       = {1'b0, win[0]} + tj;
  assign img_idx   = {row, col};
  assign flt_idx   = tap;
  assign tap_first = (tap == 4'd0);
  assign tap_last  = (tap == 4'(TAPS - 1));

endmodule

// File: rtl/systolic_conv_ctrl.sv
// Loads a 4x4 tile and 3x3 filter, issues 36 MAC operand pairs to an external PE,
// gathers the four window results and streams them out.
module systolic_conv_ctrl
  import systolic_conv_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              pe_valid,
  output logic [DATA_W-1:0] pe_a,
  output logic [DATA_W-1:0] pe_b,
  output logic              pe_first,
  output logic              pe_last,
  input  logic              pe_sum_valid,
  input  logic [DATA_W-1:0] pe_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  // Handshake: a beat moves on either stream only in a cycle where valid and
  // ready are both high; valid never depends on ready, and out_valid/out_data
  // hold until accepted.

  state_e            state_q, state_d;
  logic [4:0]        load_cnt_q, load_cnt_d;
  logic [1:0]        win_q, win_d;
  logic [3:0]        tap_q, tap_d;
  logic [2:0]        res_cnt_q, res_cnt_d;
  logic [1:0]        out_idx_q, out_idx_d;
  logic [DATA_W-1:0] img_q [IMG_SZ];
  logic [DATA_W-1:0] img_d [IMG_SZ];
  logic [DATA_W-1:0] flt_q [FLT_SZ];
  logic [DATA_W-1:0] flt_d [FLT_SZ];
  logic [DATA_W-1:0] res_q [WINDOWS];
  logic [DATA_W-1:0] res_d [WINDOWS];
  logic              pe_valid_q, pe_valid_d;
  logic              pe_first_q, pe_first_d;
  logic              pe_last_q, pe_last_d;
  logic [DATA_W-1:0] pe_a_q, pe_a_d;
  logic [DATA_W-1:0] pe_b_q, pe_b_d;

  logic [3:0] img_idx;
  logic [3:0] flt_idx;
  logic       tap_first;
  logic       tap_last;
  logic       in_beat;
  logic       capture;
  logic       issue;

  systolic_conv_addr_gen u_addr_gen (
    .win       (win_q),
    .tap       (tap_q),
    .img_idx   (img_idx),
    .flt_idx   (flt_idx),
    .tap_first (tap_first),
    .tap_last  (tap_last)
  );

  assign in_ready = (state_q == IDLE) || (state_q == LOAD_IMG) || (state_q == LOAD_FLT);
  assign in_beat  = in_valid && in_ready;
  assign capture  = pe_sum_valid && ((state_q == RUN) || (state_q == DRAIN)) &&
                    (res_cnt_q != 3'(WINDOWS));

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    win_d      = win_q;
    tap_d      = tap_q;
    res_cnt_d  = res_cnt_q;
    out_idx_d  = out_idx_q;
    img_d      = img_q;
    flt_d      = flt_q;
    res_d      = res_q;
    pe_valid_d = 1'b0;
    pe_first_d = 1'b0;
    pe_last_d  = 1'b0;
    pe_a_d     = pe_a_q;
    pe_b_d     = pe_b_q;
    issue      = 1'b0;

    if (capture) begin
      res_d[res_cnt_q[1:0]] = pe_sum;
      res_cnt_d             = res_cnt_q + 3'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (in_beat) begin
          img_d[0]   = in_data;
          load_cnt_d = 5'd1;
          state_d    = LOAD_IMG;
        end
      end
      LOAD_IMG: begin
        if (in_beat) begin
          img_d[load_cnt_q[3:0]] = in_data;
          load_cnt_d             = load_cnt_q + 5'd1;
          if (load_cnt_q == 5'(IMG_SZ - 1)) state_d = LOAD_FLT;
        end
      end
      LOAD_FLT: begin
        // Beats 16..24 land on filter slots 0..8, i.e. the low four count bits.
        if (in_beat) begin
          flt_d[load_cnt_q[3:0]] = in_data;
          if (load_cnt_q == 5'(IMG_SZ + FLT_SZ - 1)) begin
            load_cnt_d = 5'd0;
            state_d    = RUN;
            issue      = 1'b1;
          end else begin
            load_cnt_d = load_cnt_q + 5'd1;
          end
        end
      end
      RUN: begin
        // Counters point at the next pair; wrapping to (0,0) means all 36 went out.
        if (win_q == 2'd0 && tap_q == 4'd0) state_d = DRAIN;
        else                                issue   = 1'b1;
      end
      DRAIN: begin
        if (res_cnt_d == 3'(WINDOWS)) state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_idx_d = out_idx_q + 2'd1;
          if (out_idx_q == 2'(WINDOWS - 1)) begin
            state_d   = IDLE;
            res_cnt_d = 3'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      pe_valid_d = 1'b1;
      pe_a_d     = img_q[img_idx];
      pe_b_d     = flt_q[flt_idx];
      pe_first_d = tap_first;
      pe_last_d  = tap_last;
      if (tap_last) begin
        tap_d = 4'd0;
        win_d = win_q + 2'd1;
      end else begin
        tap_d = tap_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      win_q      <= '0;
      tap_q      <= '0;
      res_cnt_q  <= '0;
      out_idx_q  <= '0;
      pe_valid_q <= 1'b0;
      pe_first_q <= 1'b0;
      pe_last_q  <= 1'b0;
      pe_a_q     <= '0;
      pe_b_q     <= '0;
      for (int k = 0; k < IMG_SZ; k++)  img_q[k] <= '0;
      for (int k = 0; k < FLT_SZ; k++)  flt_q[k] <= '0;
      for (int k = 0; k < WINDOWS; k++) res_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      win_q      <= win_d;
      tap_q      <= tap_d;
      res_cnt_q  <= res_cnt_d;
      out_idx_q  <= out_idx_d;
      pe_valid_q <= pe_valid_d;
      pe_first_q <= pe_first_d;
      pe_last_q  <= pe_last_d;
      pe_a_q     <= pe_a_d;
      pe_b_q     <= pe_b_d;
      img_q      <= img_d;
      flt_q      <= flt_d;
      res_q      <= res_d;
    end
  end

  assign pe_valid  = pe_valid_q;
  assign pe_first  = pe_first_q;
  assign pe_last   = pe_last_q;
  assign pe_a      = pe_a_q;
  assign pe_b      = pe_b_q;
  assign out_valid = (state_q == OUT);
  assign out_data  = (state_q == OUT) ? res_q[out_idx_q] : '0;
  assign out_last  = (state_q == OUT) && (out_idx_q == 2'(WINDOWS - 1));
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/systolic_conv_ctrl.md
# systolic_conv_ctrl

Sequencing controller for the 8-bit one-by-one systolic convolution datapath. It buffers a 4x4 input tile and a 3x3 filter received over a valid/ready stream. It then issues the 36 multiply-accumulate operand pairs, window by window, to an external processing element (PE), collects the four 2x2 results and streams them out. It sits between the feature/filter source and the PE, and owns all ordering and handshake logic.

## Interface
- DATA_W, 8, width of pixels, weights and results
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  controller accepts a beat
- in_data  in  DATA_W  pixel or weight
- pe_valid  out  1  operand pair issued this cycle
- pe_a  out  DATA_W  pixel operand
- pe_b  out  DATA_W  weight operand
- pe_first  out  1  first tap of a window; PE clears its accumulator
- pe_last  out  1  ninth tap of a window
- pe_sum_valid  in  1  PE result valid
- pe_sum  in  DATA_W  PE window result, already truncated to DATA_W
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts a beat
- out_data  out  DATA_W  result
- out_last  out  1  fourth result beat
- busy  out  1  high in any state other than IDLE

## Operation
- States and transitions:
  - IDLE -> LOAD_IMG on the first accepted beat (that beat counts as image element 0).
  - LOAD_IMG -> LOAD_FLT after 16 beats.
  - LOAD_FLT -> RUN after 9 beats.
  - RUN -> DRAIN after 36 issues.
  - DRAIN -> OUT after 4 results are captured.
  - OUT -> IDLE after the 4th accepted output beat.
- Input order: 16 image pixels row-major (i00..i33), then 9 weights row-major (f00..f22).
- in_ready = 1 in IDLE, LOAD_IMG and LOAD_FLT; 0 otherwise. A beat transfers when in_valid && in_ready.
- RUN issues one tap per cycle, unconditionally, with no backpressure from the PE.
  - Window order: o00, o01, o10, o11.
  - Within a window, taps go (i,j) row-major from (0,0) to (2,2).
  - pe_a = img[r+i][c+j], pe_b = flt[i][j].
  - pe_first at tap 0, pe_last at tap 8.
- Result capture: pe_sum is captured on pe_sum_valid during RUN and DRAIN only. Results are stored in arrival order into slots 0..3. pe_sum_valid in any other state is ignored. A 5th or later result in the same pass is ignored.
- OUT presents slots 0..3 in order. out_data and out_valid hold stable until out_ready. out_last is asserted with slot 3.
- After OUT, the tile and filter buffers are not cleared. Every pass reloads all 25 values.

## Timing
- Reset values: state IDLE; all counters 0; result slots 0; in_ready 1; pe_valid, pe_first, pe_last, out_valid, out_last and busy 0; pe_a, pe_b and out_data 0.
- Reset asserted mid-operation returns the block to IDLE asynchronously. Partially loaded data and captured results are abandoned.
- Load phase: 25 cycles minimum. Gaps in in_valid stall the load without losing position.
- RUN: exactly 36 consecutive cycles with pe_valid = 1, starting the cycle after the 25th input beat is accepted.
- pe_* outputs are registered. pe_valid is low outside RUN; pe_a and pe_b hold their last values.
- DRAIN has no timeout. The block waits indefinitely for the 4th result.
- OUT is entered the cycle after the 4th capture. With out_ready held high, the 4 beats take 4 cycles.
- If pe_sum_valid coincides with the final RUN issue cycle, the result is captured and the transition to DRAIN still occurs.

## Structure
- Shared package holds:
  - Tile constants: IMG_N = 4, K = 3, OUT_N = 2, TAPS = 9, WINDOWS = 4.
  - State enum: IDLE, LOAD_IMG, LOAD_FLT, RUN, DRAIN, OUT.
- The single sub-module is systolic_conv_addr_gen. It maps the window and tap counters to an image index ((r+i)*4 + c+j) and a filter index (i*3+j), and flags the first and last tap.
- Buffers are flat register arrays (16 + 9 + 4 entries).

## Test plan
- Nominal: bench PE model is a MAC with 1-cycle result latency. Load image 9,8,2,6,0,4,1,6,4,10,1,1,2,2,9,9 and filter 3,2,0,2,0,1,3,1,1 -> outputs 67, 74, 34, 59, with out_last on 59.
- Operand order: during RUN, check all 36 (pe_a, pe_b) pairs against the row-major window/tap order. The first pair is (9,3); the last is (9,1), with pe_last set.
- Backpressure: random in_valid gaps during load and random out_ready low during OUT -> same 4 results; out_data stable while out_valid && !out_ready.
- Slow PE: result latency 7 cycles -> block sits in DRAIN with busy = 1 until the 4th result, then outputs the correct values.
- Reset mid-RUN at tap 20 -> next cycle shows IDLE outputs; a fresh full load gives the nominal results.
- Spurious results: pe_sum_valid pulses in IDLE, during load and in OUT -> ignored; results unchanged.
